univ_reg: RTL
=============

Name: univ_reg

Overview:
- Parametrised WIDTH-bit multi-mode register. Successor to the single-bit D/T/SR/JK flip-flops.
- One block provides load, toggle, set-mask, shift left/right and up/down count, with per-cycle mode select.
- Used as the general-purpose state element: shift chains, event counters and flag registers.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RESET_VAL, 0, value of q after async reset and after sync clear (WIDTH bits).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- clr, input, 1, synchronous clear to RESET_VAL; overrides en and mode.
- en, input, 1, clock enable; when low, q holds.
- mode, input, 3, operation select (encodings in Behaviour).
- d, input, WIDTH, parallel data, or mask for TOGGLE/SET.
- sin, input, 1, serial input for shift modes.
- q, output, WIDTH, registered state.
- sout, output, 1, serial output (combinational from q and mode).
- tc, output, 1, terminal count (combinational).
- wrap, output, 1, registered one-cycle pulse on counter wrap.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high on port reset.
  - Clock port is clk; reset port is reset.
- Reset:
  - reset high forces q=RESET_VAL and wrap=0 immediately, without waiting for a clock edge.
  - Reset held high overrides all inputs.
  - Reset asserted mid-operation (e.g. mid-count or mid-shift) discards the operation; no wrap pulse follows.
- Priority at each rising clk edge: reset > clr > en.
  - clr=1: q<=RESET_VAL, wrap<=0, regardless of en and mode.
  - en=0 and clr=0: q holds, wrap<=0.
- Modes (applied when en=1 and clr=0); single-cycle latency, result visible in q the cycle after the edge:
  - 000 HOLD: q<=q.
  - 001 LOAD: q<=d.
  - 010 TOGGLE: q<=q^d. Per-bit T flip-flop; d=all-ones inverts every bit.
  - 011 SET: q<=q|d.
  - 100 SHL: q<={q[WIDTH-2:0],sin}.
  - 101 SHR: q<={sin,q[WIDTH-1:1]}.
  - 110 CNT_UP: q<=q+1, modulo 2^WIDTH.
  - 111 CNT_DN: q<=q-1, modulo 2^WIDTH.
- sout:
  - q[WIDTH-1] in SHL mode.
  - q[0] in SHR mode.
  - q[WIDTH-1] in all other modes.
- tc:
  - 1 when mode=CNT_UP and q=all-ones.
  - 1 when mode=CNT_DN and q=0.
  - 0 otherwise.
  - tc ignores en and clr.
- wrap:
  - Set to 1 for exactly one cycle after an enabled count edge taken while tc=1.
  - 0 on every other edge.
  - Not asserted by LOAD of all-ones/zero, or by SHL/SHR.
- Consecutive wraps with tc high every cycle (WIDTH width only reachable by up/down alternation) produce back-to-back pulses. No merging.
- Mode may change every cycle. No state is kept across modes other than q.

Optional Feature:
- Macro: UNIV_REG_SAT_EN.
- Defined:
  - CNT_UP at all-ones and CNT_DN at 0 hold q (saturate).
  - wrap is tied to 0.
  - tc still reports the limit.
- Undefined: modulo wrap and wrap pulse as specified above.

Decomposition:
- Package univ_reg_pkg holds:
  - mode_e enum (3-bit): HOLD, LOAD, TOGGLE, SET, SHL, SHR, CNT_UP, CNT_DN.
  - A next-state function parametrised by width.
- No sub-module required. The next-state logic is one combinational block feeding a single WIDTH-bit register plus the wrap flop.

Test Plan (WIDTH=8, RESET_VAL=0):
- Reset and load: assert reset between edges -> q=0x00 without a clock edge. Then LOAD d=0xA5 -> q=0xA5 next cycle. Then en=0 for 3 cycles -> q stays 0xA5.
- TOGGLE and SET: TOGGLE d=0xFF from 0xA5 -> 0x5A. SET d=0x81 -> 0xDB. clr=1 with en=0, mode=LOAD -> 0x00.
- Shift:
  - SHL from 0x80 with sin=1 -> q=0x01. sout=1 before the edge.
  - SHR from 0x01 with sin=0 -> q=0x00. sout=1 before the edge.
- Count-up wrap:
  - LOAD 0xFE, then CNT_UP x3 -> q sequence 0xFF, 0x00, 0x01.
  - tc=1 only while q=0xFF.
  - wrap=1 only in the cycle q=0x00.
- Count-down wrap and saturation:
  - CNT_DN from 0x00 -> 0xFF, wrap pulses once.
  - With UNIV_REG_SAT_EN, same stimulus -> q stays 0x00, wrap=0, tc=1.
- Mid-operation reset: counting up at q=0xFF, assert reset asynchronously -> q=0x00, no wrap pulse after release. Counting resumes from 0x00 then 0x01.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - mode encodings and width-parametrised next-state function for univ_reg
// Optional saturation controlled by macro UNIV_REG_SAT_EN.
package univ_reg_pkg;

  typedef enum logic [2:0] {
    HOLD   = 3'b000,
    LOAD   = 3'b001,
    TOGGLE = 3'b010,
    SET    = 3'b011,
    SHL    = 3'b100,
    SHR    = 3'b101,
    CNT_UP = 3'b110,
    CNT_DN = 3'b111
  } mode_e;

  // Parametrised class wrapper gives a width-generic static function.
  virtual class univ_reg_ns #(parameter int W = 8);
    static function logic [W-1:0] next_q(input mode_e mode, input logic [W-1:0] q,
                                         input logic [W-1:0] d, input logic sin);
      logic [W-1:0] nq;
      nq = q;
      case (mode)
        HOLD:   nq = q;
        LOAD:   nq = d;
        TOGGLE: nq = q ^ d;
        SET:    nq = q | d;
        SHL:    nq = {q[W-2:0], sin};
        SHR:    nq = {sin, q[W-1:1]};
`ifdef UNIV_REG_SAT_EN
        CNT_UP: nq = (q == {W{1'b1}}) ? q : q + 1'b1;
        CNT_DN: nq = (q == {W{1'b0}}) ? q : q - 1'b1;
`else
        CNT_UP: nq = q + 1'b1;
        CNT_DN: nq = q - 1'b1;
`endif
        default: nq = q;
      endcase
      return nq;
    endfunction
  endclass

endpackage

// File: rtl/univ_reg.sv
// rtl/univ_reg.sv - WIDTH-bit multi-mode register (load/toggle/set/shift/count)
// Define UNIV_REG_SAT_EN to make counters saturate and tie wrap low.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  assign tc   = ((mode_s == CNT_UP) && (q_q == {WIDTH{1'b1}})) ||
                ((mode_s == CNT_DN) && (q_q == {WIDTH{1'b0}}));
  assign sout = (mode_s == SHR) ? q_q[0] : q_q[WIDTH-1];

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d = univ_reg_ns#(WIDTH)::next_q(mode_s, q_q, d, sin);
`ifndef UNIV_REG_SAT_EN
      // tc is only ever high in a count mode, so it marks the wrapping edge.
      wrap_d = tc;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule
